// File: rtl/ldpc_pkg.sv
// ldpc_pkg
// Shared definitions for the LDPC variable-node datapath.
//   - default LLR width and binary-point position
//   - FSM state encoding for the column-sum variable-node unit
//   - clog2 / index-width helpers usable in constant expressions
//   - sat(): symmetric two's-complement clamp to +/-(2^(w-1)-1)
package ldpc_pkg;

    localparam int LLR_W_DEF    = 16;
    localparam int LLR_FRAC_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } vnu_state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // ext_idx must be at least one bit wide, even for a degree-1 column.
    function automatic int idx_width(input int dv);
        return (clog2(dv) > 1) ? clog2(dv) : 1;
    endfunction

    // Symmetric clamp: the most negative code -2^(w-1) is never produced,
    // so negating a saturated value can never overflow downstream.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (v > lim) begin
            return lim;
        end
        if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

endpackage

// File: rtl/column_sum_vnu_if.sv
// column_sum_vnu_if
// Bundles the column request, result and extrinsic-message stream of the
// variable-node unit.
//   master (producer/consumer side): drives start, llr_ch, r_in, ext_ready
//   slave  (the unit):               drives busy, sum, hard_bit, ext_valid,
//                                    ext_idx, ext_out, done
// r_in is flattened: message r0 occupies bits [W-1:0].
interface column_sum_vnu_if
    import ldpc_pkg::*;
#(
    parameter int W  = LLR_W_DEF,
    parameter int DV = 3
) ();

    localparam int IDX_W = idx_width(DV);

    logic                    start;
    logic signed [W-1:0]     llr_ch;
    logic        [DV*W-1:0]  r_in;
    logic                    busy;
    logic signed [W-1:0]     sum;
    logic                    hard_bit;
    logic                    ext_valid;
    logic                    ext_ready;
    logic        [IDX_W-1:0] ext_idx;
    logic signed [W-1:0]     ext_out;
    logic                    done;

    modport master (
        output start, llr_ch, r_in, ext_ready,
        input  busy, sum, hard_bit, ext_valid, ext_idx, ext_out, done
    );

    modport slave (
        input  start, llr_ch, r_in, ext_ready,
        output busy, sum, hard_bit, ext_valid, ext_idx, ext_out, done
    );

endinterface

// File: rtl/llr_sat_addsub.sv
// llr_sat_addsub
// ACC_W-wide add or subtract with both the full-width result and a
// symmetrically saturated W-bit tap.
//   i_a, i_b : signed ACC_W operands
//   i_sub    : 0 -> a + b, 1 -> a - b
//   o_res    : full-precision result (ACC_W, never overflows for our ranges)
//   o_sat    : result clamped to +/-(2^(W-1)-1)
module llr_sat_addsub
    import ldpc_pkg::*;
#(
    parameter int W     = LLR_W_DEF,
    parameter int ACC_W = LLR_W_DEF + 3
) (
    input  logic signed [ACC_W-1:0] i_a,
    input  logic signed [ACC_W-1:0] i_b,
    input  logic                    i_sub,
    output logic signed [ACC_W-1:0] o_res,
    output logic signed [W-1:0]     o_sat
);

    logic signed [ACC_W-1:0] w_res;
    logic signed [63:0]      w_wide;

    always_comb begin
        w_res  = i_sub ? (i_a - i_b) : (i_a + i_b);
        w_wide = {{(64 - ACC_W){w_res[ACC_W-1]}}, w_res};
        o_sat  = W'(sat(w_wide, W));
    end

    assign o_res = w_res;

endmodule

// File: rtl/column_sum_vnu.sv
// column_sum_vnu
// Variable-node processor for one LDPC column of degree DV.
// A column is accepted on start, the channel LLR plus DV check messages are
// accumulated one per cycle, the saturated posterior (sum) and its sign
// (hard_bit) are registered, and then the DV extrinsic messages
// sat(acc - r_i) are streamed out under ext_valid/ext_ready.
//   clk : rising-edge clock
//   clr : asynchronous active-high reset (aborts any column in flight)
//   bus : column_sum_vnu_if slave modport (request, results, ext stream)
// FRAC only documents the binary point of the LLRs; the datapath is
// integer throughout.
module column_sum_vnu
    import ldpc_pkg::*;
#(
    parameter int W    = LLR_W_DEF,
    parameter int FRAC = LLR_FRAC_DEF,
    parameter int DV   = 3
) (
    input logic             clk,
    input logic             clr,
    column_sum_vnu_if.slave bus
);

    localparam int               IDX_W    = idx_width(DV);
    // One guard bit per doubling of the DV+1 terms plus one spare, so the
    // accumulation and the later subtraction can never wrap.
    localparam int               ACC_W    = W + clog2(DV + 1) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DV - 1);

    vnu_state_t              r_state;
    vnu_state_t              w_state_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [W-1:0]     r_msg [DV];
    logic signed [W-1:0]     r_sum;
    logic                    r_hard;
    logic                    r_done;

    logic                    w_accept;
    logic                    w_xfer;
    logic                    w_last;
    logic                    w_emit;
    logic signed [W-1:0]     w_msg;
    logic signed [ACC_W-1:0] w_msg_ext;
    logic signed [ACC_W-1:0] w_llr_ext;
    logic signed [ACC_W-1:0] w_acc_sum;
    logic signed [W-1:0]     w_acc_sat;
    logic signed [ACC_W-1:0] w_ext_unused;
    logic signed [W-1:0]     w_ext_sat;
    logic [31:0]             w_frac_unused;

    assign w_frac_unused = FRAC;

    assign w_msg     = r_msg[r_idx];
    assign w_msg_ext = {{(ACC_W - W){w_msg[W-1]}}, w_msg};
    assign w_llr_ext = {{(ACC_W - W){bus.llr_ch[W-1]}}, bus.llr_ch};
    assign w_last    = (r_idx == LAST_IDX);
    assign w_emit    = (r_state == ST_EMIT);

    // Accumulate path: next acc, and its saturated tap which becomes sum on
    // the last accumulate cycle.
    llr_sat_addsub #(.W(W), .ACC_W(ACC_W)) u_acc_path (
        .i_a   (r_acc),
        .i_b   (w_msg_ext),
        .i_sub (1'b0),
        .o_res (w_acc_sum),
        .o_sat (w_acc_sat)
    );

    // Extrinsic path: posterior minus the message currently being returned.
    llr_sat_addsub #(.W(W), .ACC_W(ACC_W)) u_ext_path (
        .i_a   (r_acc),
        .i_b   (w_msg_ext),
        .i_sub (1'b1),
        .o_res (w_ext_unused),
        .o_sat (w_ext_sat)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_last) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (bus.ext_ready) begin
                    w_xfer = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_idx  <= '0;
            r_acc  <= '0;
            r_sum  <= '0;
            r_hard <= 1'b0;
            r_done <= 1'b0;
            for (int i = 0; i < DV; i++) begin
                r_msg[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_acc <= w_llr_ext;
                r_idx <= '0;
                for (int i = 0; i < DV; i++) begin
                    r_msg[i] <= bus.r_in[i*W +: W];
                end
            end else if (r_state == ST_ACCUM) begin
                r_acc <= w_acc_sum;
                if (w_last) begin
                    r_idx  <= '0;
                    r_sum  <= w_acc_sat;
                    r_hard <= w_acc_sat[W-1];
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end else if (w_xfer) begin
                if (w_last) begin
                    r_idx  <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.sum       = r_sum;
    assign bus.hard_bit  = r_hard;
    assign bus.ext_valid = w_emit;
    assign bus.ext_idx   = r_idx;
    // Forced to zero outside EMIT so an idle or reset unit shows no stale value.
    assign bus.ext_out   = w_emit ? w_ext_sat : '0;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_column_sum_vnu.sv
module tb_column_sum_vnu;
    import ldpc_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    column_sum_vnu_if #(.W(W), .DV(3)) b3 ();
    column_sum_vnu_if #(.W(W), .DV(1)) b1 ();

    column_sum_vnu #(.W(W), .FRAC(8), .DV(3)) dut3 (.clk(clk), .clr(clr), .bus(b3));
    column_sum_vnu #(.W(W), .FRAC(8), .DV(1)) dut1 (.clk(clk), .clr(clr), .bus(b1));

    typedef struct {
        int idx;
        int val;
        int sum;
        int hard;
        bit last;
    } exp_t;

    exp_t q3[$];
    exp_t q1[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   last_sum3 = 0;
    bit   rnd_ready = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    function automatic int satv(input longint v);
        if (v > 32767) return 32767;
        if (v < -32767) return -32767;
        return int'(v);
    endfunction

    // Reference model: posterior = llr + sum(r), extrinsic_i = posterior - r_i,
    // both clamped symmetrically.
    task automatic push3(input int llr, input int r0, input int r1, input int r2);
        int     r[3];
        longint tot;
        int     s;
        exp_t   e;
        r[0] = r0; r[1] = r1; r[2] = r2;
        tot = longint'(llr) + longint'(r0) + longint'(r1) + longint'(r2);
        s = satv(tot);
        for (int i = 0; i < 3; i++) begin
            e.idx  = i;
            e.val  = satv(tot - longint'(r[i]));
            e.sum  = s;
            e.hard = (s < 0) ? 1 : 0;
            e.last = (i == 2);
            q3.push_back(e);
        end
        last_sum3 = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; start is sampled on the next edge.
    task automatic drive3(input int llr, input int r0, input int r1, input int r2, input bit accept);
        b3.start  = 1'b1;
        b3.llr_ch = llr[15:0];
        b3.r_in   = {r2[15:0], r1[15:0], r0[15:0]};
        if (accept) push3(llr, r0, r1, r2);
        tick();
        b3.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int exp_ticks);
        int n;
        n = 0;
        while (b3.done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check({nm, "_seen"}, int'(b3.done), 1);
        if (exp_ticks >= 0) check(nm, n, exp_ticks);
    endtask

    task automatic wait_idx1(input string nm, input int exp_ticks);
        int n;
        n = 0;
        while (!(b3.ext_valid === 1'b1 && int'(b3.ext_idx) == 1) && n < 300) begin
            tick();
            n++;
        end
        check(nm, n, exp_ticks);
    endtask

    // Monitor for the DV=3 unit: pops the scoreboard on every transfer, checks
    // hold-while-stalled, and checks done against the last-transfer history.
    bit pend3  = 1'b0;
    bit stall3 = 1'b0;
    int hidx3, hval3;
    always @(negedge clk) begin
        exp_t e;
        if (clr) begin
            pend3  = 1'b0;
            stall3 = 1'b0;
        end else begin
            check("done3", int'(b3.done), int'(pend3));
            pend3 = 1'b0;
            if (stall3) begin
                check("hold_valid3", int'(b3.ext_valid), 1);
                check("hold_idx3", int'(b3.ext_idx), hidx3);
                check("hold_val3", int'(b3.ext_out), hval3);
            end
            stall3 = 1'b0;
            if (b3.ext_valid === 1'b1) begin
                if (b3.ext_ready !== 1'b1) begin
                    stall3 = 1'b1;
                    hidx3  = int'(b3.ext_idx);
                    hval3  = int'(b3.ext_out);
                end else if (q3.size() == 0) begin
                    check("extra_ext3", q3.size(), 1);
                end else begin
                    e = q3.pop_front();
                    check("ext_idx3", int'(b3.ext_idx), e.idx);
                    check("ext_out3", int'(b3.ext_out), e.val);
                    check("sum3", int'(b3.sum), e.sum);
                    check("hard3", int'(b3.hard_bit), e.hard);
                    pend3 = e.last;
                end
            end
        end
    end

    bit pend1 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (clr) begin
            pend1 = 1'b0;
        end else begin
            check("done1", int'(b1.done), int'(pend1));
            pend1 = 1'b0;
            if (b1.ext_valid === 1'b1 && b1.ext_ready === 1'b1) begin
                if (q1.size() == 0) begin
                    check("extra_ext1", q1.size(), 1);
                end else begin
                    e = q1.pop_front();
                    check("ext_idx1", int'(b1.ext_idx), e.idx);
                    check("ext_out1", int'(b1.ext_out), e.val);
                    check("sum1", int'(b1.sum), e.sum);
                    check("hard1", int'(b1.hard_bit), e.hard);
                    pend1 = e.last;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_ready) b3.ext_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        exp_t e;
        clr = 1'b1;
        b3.start = 1'b0; b3.llr_ch = '0; b3.r_in = '0; b3.ext_ready = 1'b1;
        b1.start = 1'b0; b1.llr_ch = '0; b1.r_in = '0; b1.ext_ready = 1'b1;
        repeat (3) tick();

        check("rst_busy", int'(b3.busy), 0);
        check("rst_valid", int'(b3.ext_valid), 0);
        check("rst_sum", int'(b3.sum), 0);
        check("rst_hard", int'(b3.hard_bit), 0);
        check("rst_ext_out", int'(b3.ext_out), 0);
        check("rst_ext_idx", int'(b3.ext_idx), 0);
        check("rst_done", int'(b3.done), 0);
        check("rst_busy1", int'(b1.busy), 0);
        clr = 1'b0;
        tick();

        // Case 1 with latency checks
        drive3(128, -205, -154, 154, 1'b1);
        tick(); tick();
        check("t1_valid_pre", int'(b3.ext_valid), 0);
        tick();
        check("t1_valid_rise", int'(b3.ext_valid), 1);
        check("t1_sum", int'(b3.sum), -77);
        check("t1_hard", int'(b3.hard_bit), 1);
        wait_done("t1_done", 3);
        tick();

        // Case 2: positive then negative saturation
        drive3(32000, 32000, 32000, -100, 1'b1);
        wait_done("t2a_done", 6);
        tick();
        drive3(-32768, -32768, -32768, -32768, 1'b1);
        wait_done("t2b_done", 6);
        check("t2b_sum", int'(b3.sum), -32767);
        tick();

        // Case 3: three-cycle stall on idx 1
        drive3(128, -205, -154, 154, 1'b1);
        wait_idx1("t3_idx1", 4);
        b3.ext_ready = 1'b0;
        repeat (3) tick();
        b3.ext_ready = 1'b1;
        wait_done("t3_done", 2);
        tick();

        // Case 4: start while busy ignored, start in done cycle accepted
        drive3(128, -205, -154, 154, 1'b1);
        tick();
        drive3(1000, 1, 2, 3, 1'b0);
        wait_done("t4a_done", 4);
        drive3(32000, 32000, 32000, -100, 1'b1);
        wait_done("t4b_done", 6);
        tick();

        // Case 5: abort mid-EMIT
        drive3(128, -205, -154, 154, 1'b1);
        wait_idx1("t5_idx1", 4);
        clr = 1'b1;
        #1;
        check("t5_busy", int'(b3.busy), 0);
        check("t5_valid", int'(b3.ext_valid), 0);
        check("t5_sum", int'(b3.sum), 0);
        check("t5_hard", int'(b3.hard_bit), 0);
        check("t5_ext_out", int'(b3.ext_out), 0);
        check("t5_ext_idx", int'(b3.ext_idx), 0);
        check("t5_done", int'(b3.done), 0);
        q3.delete();
        tick(); tick();
        clr = 1'b0;
        repeat (4) tick();
        drive3(128, -205, -154, 154, 1'b1);
        wait_done("t5_done_after", 6);

        // Randomized columns with random back-pressure, back-to-back
        rnd_ready = 1'b1;
        for (int k = 0; k < 25; k++) begin
            drive3(int'($urandom_range(0, 65535)) - 32768,
                   int'($urandom_range(0, 65535)) - 32768,
                   int'($urandom_range(0, 65535)) - 32768,
                   int'($urandom_range(0, 65535)) - 32768, 1'b1);
            wait_done("rnd_done", -1);
        end
        rnd_ready = 1'b0;
        tick();
        b3.ext_ready = 1'b1;

        // sum/hard_bit hold after the column
        repeat (4) tick();
        check("hold_sum", int'(b3.sum), last_sum3);
        check("hold_hard", int'(b3.hard_bit), (last_sum3 < 0) ? 1 : 0);

        // Case 6: DV=1 unit
        e.idx = 0; e.val = satv(-300); e.sum = satv(-250); e.hard = 1; e.last = 1'b1;
        q1.push_back(e);
        b1.start  = 1'b1;
        b1.llr_ch = 16'shfed4;
        b1.r_in   = 16'd50;
        tick();
        b1.start = 1'b0;
        n = 0;
        while (b1.done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("t6_done_seen", int'(b1.done), 1);
        check("t6_done_lat", n, 2);
        check("t6_sum", int'(b1.sum), -250);
        tick(); tick();

        check("q3_empty", q3.size(), 0);
        check("q1_empty", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/column_sum_vnu.md
Name: column_sum_vnu

Overview:
- Parametrised successor to the three-input column-sum calculator used in the LDPC belief-propagation decoder.
- Performs variable-node processing for one column of degree DV: accumulates the channel LLR plus DV check-to-variable messages using one shared adder, and produces a saturated posterior sum and hard decision.
- Then streams the DV extrinsic messages (posterior minus each incoming message) back to the check-node side under a valid/ready handshake.
- Fixed-point two's-complement LLRs replace the single-precision float path, so width and degree are generic.

Parameters:
- W, 16: LLR/message width, two's complement.
- FRAC, 8: fractional bits. Documentation and testbench scaling only; no RTL effect.
- DV, 3: column degree, i.e. number of check messages (DV >= 1).
- IDX_W, max(1, clog2(DV)): width of ext_idx (derived).

Ports:
- clk, in, 1: rising-edge clock.
- clr, in, 1: asynchronous active-high reset.
- start, in, 1: begin a column. Sampled only when busy=0.
- llr_ch, in, W: channel LLR. Latched on an accepted start.
- r_in, in, DV*W: check messages, flattened. Message r0 occupies bits [W-1:0]. Latched on an accepted start.
- busy, out, 1: high from the edge after an accepted start until the final ext transfer.
- sum, out, W: saturated posterior LLR. Held until the next accepted start.
- hard_bit, out, 1: sign of sum (1 = negative). Held with sum.
- ext_valid, out, 1: extrinsic message available.
- ext_ready, in, 1: consumer accepts ext_out.
- ext_idx, out, IDX_W: index i of the current extrinsic message.
- ext_out, out, W: saturated value of (acc - r_i).
- done, out, 1: one-cycle pulse after the last extrinsic transfer.

Behaviour:
Reset:
- clr asserted at any time forces state IDLE immediately (asynchronous).
- All outputs and internal registers go to 0.
- An aborted column produces no done and no further ext_valid.

Internal widths:
- Accumulator width ACC_W = W + clog2(DV+1) + 1.
- All sums are sign-extended into ACC_W, so nothing overflows internally.

Saturation:
- Symmetric clamp to [-(2^(W-1)-1), +(2^(W-1)-1)], applied only to sum and ext_out.
- Input -2^(W-1) is accepted unchanged.

FSM, IDLE -> ACCUM -> EMIT -> IDLE:
- IDLE: if start=1, latch llr_ch and r_in, set acc <= sext(llr_ch), idx <= 0, go to ACCUM.
- ACCUM: each cycle acc <= acc + r_idx and idx++. After DV cycles:
  - sum <= sat(final acc) and hard_bit <= sign of that result, registered in the same edge;
  - idx <= 0; go to EMIT.
- EMIT: ext_valid=1, ext_idx=idx, ext_out=sat(acc - r_idx), all combinational from registers.
  - A transfer happens on an edge where ext_valid and ext_ready are both 1; each transfer increments idx.
  - When ext_ready=0, ext_out and ext_idx hold stable.
  - On the transfer with idx=DV-1: go to IDLE and set done <= 1 for exactly one cycle.
- start is ignored while busy=1. A start during the done cycle is accepted (back-to-back columns).

Latency:
- start sampled at edge 0, ext_valid rises after edge DV.
- With ext_ready held at 1, transfers occur at edges DV+1 .. 2DV and done is high in the cycle after edge 2DV.
- Total 2DV+1 cycles per column.

Boundary cases:
- DV=1: the single ext_out equals sat(llr_ch).
- sum and hard_bit are stable from the edge ext_valid rises until the next accepted start.

Decomposition:
- Package ldpc_pkg holds:
  - default LLR width and FRAC;
  - a clog2 function;
  - a symmetric-saturate function, sat(value, W).
- Sub-module llr_sat_addsub: ACC_W-wide add/subtract with a W-bit saturated output. Used twice: the accumulate path (saturated tap for sum) and the extrinsic subtract path.

Test Plan (W=16, FRAC=8, DV=3):
1. llr_ch=128 (0.5), r=(-205,-154,154) (-0.8,-0.6,0.6), ext_ready=1 -> sum=-77, hard_bit=1; ext (idx,val) = (0,128),(1,77),(2,-231) at edges 4,5,6; done high in cycle 7 only.
2. llr_ch=32000, r=(32000,32000,-100) -> sum=32767, hard_bit=0; ext0=32767, ext1=32767, ext2=32767. Then all inputs -32768 -> sum=-32767, every ext_out=-32767.
3. Case 1 with ext_ready low for 3 cycles while ext_idx=1 -> ext_idx=1 and ext_out=77 held stable for those cycles; done delayed by exactly 3 cycles; no lost or duplicated index.
4. start pulsed again at the 2nd ACCUM cycle with different data -> ignored; results identical to case 1. Then start asserted in the done cycle with case-2 data -> accepted; case-2 results follow with no gap.
5. clr asserted mid-EMIT (after idx 0 is transferred) -> all outputs 0 immediately; no done. A fresh start then reproduces case 1 exactly.
6. Rebuild with DV=1, llr_ch=-300, r0=50 -> sum=-250, hard_bit=1, single ext (0,-300), done after 3 cycles.
